// File: rtl/div_seq.sv
// div_seq: iterative 32-bit signed/unsigned restoring divider for MIPS DIV/DIVU.
// One 33-bit subtracting adder is reused over 32 iterations, then a FIX cycle
// applies sign correction and the {rem, quot} pair is held until res_ready.
// Optional build macro: DIV_ZERO_FAST_EN -- when defined, a zero divisor skips
// the iteration loop and goes straight from IDLE to FIX.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_valid,
    output logic             div_ready,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] div_a,
    input  logic [WIDTH-1:0] div_b,
    input  logic             cancel,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_quot,
    output logic [WIDTH-1:0] res_rem
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Two's complement negate when neg is set; 0x80000000 maps to itself.
    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic neg);
        logic signed [WIDTH-1:0] sx;
        sx = $signed(x);
        return neg ? WIDTH'(-sx) : x;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             carry;
    logic             unused_diff_msb;

    // Shared subtracting adder: trial - {0,|b|} as trial + ~{0,|b|} + 1.
    // The partial remainder stays below |b|, so it fits in WIDTH bits and the
    // difference MSB is always zero when it is kept.
    always_comb begin
        trial = {r_q, q_q[WIDTH-1]};
        {carry, diff} = {1'b0, trial} + {1'b0, ~{1'b0, b_q}} + {{(WIDTH+1){1'b0}}, 1'b1};
    end
    assign unused_diff_msb = diff[WIDTH];

    // Next-state and datapath update for the divide sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        quot_d      = quot_q;
        rem_d       = rem_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        b_d         = b_q;
        r_d         = r_q;
        q_d         = q_q;

        case (state_q)
            IDLE: begin
                if (div_valid) begin
                    sa_d    = div_signed & div_a[WIDTH-1];
                    sb_d    = div_signed & div_b[WIDTH-1];
                    b_d     = neg_if(div_b, div_signed & div_b[WIDTH-1]);
                    r_d     = '0;
                    q_d     = neg_if(div_a, div_signed & div_a[WIDTH-1]);
                    cnt_d   = '0;
                    state_d = CALC;
`ifdef DIV_ZERO_FAST_EN
                    // Zero divisor: every iteration would succeed, so load the
                    // final Q/R directly and skip the loop.
                    if (div_b == '0) begin
                        q_d     = '1;
                        r_d     = neg_if(div_a, div_signed & div_a[WIDTH-1]);
                        state_d = FIX;
                    end
`endif
                end
            end
            CALC: begin
                if (carry) begin
                    r_d = diff[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_d = trial[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quot_d  = neg_if(q_q, sa_q ^ sb_q);
                rem_d   = neg_if(r_q, sa_q);
                state_d = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush wins over accept and result handshake alike.
        if (cancel) begin
            state_d = IDLE;
            quot_d  = '0;
            rem_d   = '0;
        end

        busy_d      = (state_d != IDLE);
        res_valid_d = (state_d == DONE);
    end

    // Control and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            quot_q      <= '0;
            rem_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
        end
    end

    // Iteration datapath; always reloaded on accept, so no reset needed.
    always_ff @(posedge clk) begin
        sa_q <= sa_d;
        sb_q <= sb_d;
        b_q  <= b_d;
        r_q  <= r_d;
        q_q  <= q_d;
    end

    assign div_ready = (state_q == IDLE);
    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign res_quot  = quot_q;
    assign res_rem   = rem_q;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: self-checking bench for div_seq using directed cases and
// randomized operands against an arithmetic reference model.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_valid;
    logic        div_ready;
    logic        div_signed;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        cancel;
    logic        busy;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_quot;
    logic [31:0] res_rem;

    int checks = 0;
    int errors = 0;

    div_seq #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .div_valid  (div_valid),
        .div_ready  (div_ready),
        .div_signed (div_signed),
        .div_a      (div_a),
        .div_b      (div_b),
        .cancel     (cancel),
        .busy       (busy),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_quot   (res_quot),
        .res_rem    (res_rem)
    );

    always #5 clk = ~clk;

    // Reference: divide magnitudes, then sign-correct (remainder follows dividend).
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                    output logic [31:0] q, output logic [31:0] r);
        logic        na, nb;
        logic [31:0] ma, mb, uq, ur;
        na = s & a[31];
        nb = s & b[31];
        ma = na ? 32'd0 - a : a;
        mb = nb ? 32'd0 - b : b;
        if (mb == 32'd0) begin
            uq = 32'hFFFF_FFFF;
            ur = ma;
        end else begin
            uq = ma / mb;
            ur = ma % mb;
        end
        q = (na ^ nb) ? 32'd0 - uq : uq;
        r = na ? 32'd0 - ur : ur;
    endfunction

    function automatic int exp_latency(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
        return (b == 32'd0) ? 2 : 34;
`else
        return 34;
`endif
    endfunction

    // Issue one request, wait for the result, check it; optionally complete handshake.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [31:0] eq, input logic [31:0] er, input int elat,
                          input bit do_ack, input string name);
        int lat;
        bit got;
        checks++;
        if (div_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s div_ready before accept: got %b want 1", name, div_ready);
        end
        div_valid = 1'b1; div_a = a; div_b = b; div_signed = s;
        @(posedge clk); #1;
        div_valid = 1'b0;
        lat = 1;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (res_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (!got || lat != elat) begin
            errors++;
            $display("FAIL %s latency: got %0d (seen=%0b) want %0d", name, lat, got, elat);
        end
        checks++;
        if (res_quot !== eq) begin
            errors++;
            $display("FAIL %s quot: got %h want %h", name, res_quot, eq);
        end
        checks++;
        if (res_rem !== er) begin
            errors++;
            $display("FAIL %s rem: got %h want %h", name, res_rem, er);
        end
        if (do_ack) begin
            res_ready = 1'b1;
            @(posedge clk); #1;
            res_ready = 1'b0;
            checks++;
            if (busy !== 1'b0 || div_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s after ack: busy=%b ready=%b want busy=0 ready=1", name, busy, div_ready);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; div_valid = 1'b0; div_signed = 1'b0; div_a = '0; div_b = '0;
        cancel = 1'b0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (div_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0 ||
            res_quot !== 32'd0 || res_rem !== 32'd0) begin
            errors++;
            $display("FAIL reset: ready=%b busy=%b valid=%b quot=%h rem=%h want 1 0 0 0 0",
                     div_ready, busy, res_valid, res_quot, res_rem);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 34, 1'b1, "divu_100_7");
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34, 1'b1, "div_m7_2");
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 34, 1'b1, "div_7_m2");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 34, 1'b1, "div_ovf");
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 34, 1'b1, "divu_max_1");
        run_op(32'd123, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd123, exp_latency(32'd0), 1'b1, "divu_123_0");
        run_op(32'hFFFF_FFFB, 32'd0, 1'b1, 32'h0000_0001, 32'hFFFF_FFFB, exp_latency(32'd0), 1'b1, "div_m5_0");
    endtask

    task automatic test_random();
        logic [31:0] a, b, eq, er;
        logic        s;
        for (int n = 0; n < 30; n++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = $urandom_range(1, 100);
                2: b = 32'd0;
                default: b = 32'd0 - $urandom_range(1, 50);
            endcase
            s = 1'($urandom_range(0, 1));
            ref_div(a, b, s, eq, er);
            run_op(a, b, s, eq, er, exp_latency(b), 1'b1, "random");
        end
    endtask

    task automatic test_cancel();
        div_valid = 1'b1; div_a = 32'd100; div_b = 32'd7; div_signed = 1'b0;
        @(posedge clk); #1;
        div_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || div_ready !== 1'b1 ||
            res_quot !== 32'd0 || res_rem !== 32'd0) begin
            errors++;
            $display("FAIL cancel_calc: busy=%b valid=%b ready=%b quot=%h rem=%h want 0 0 1 0 0",
                     busy, res_valid, div_ready, res_quot, res_rem);
        end
        run_op(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 34, 1'b1, "after_cancel");
    endtask

    task automatic test_cancel_idle();
        bit seen;
        div_valid = 1'b1; cancel = 1'b1; div_a = 32'd5; div_b = 32'd1; div_signed = 1'b0;
        @(posedge clk); #1;
        div_valid = 1'b0; cancel = 1'b0;
        checks++;
        if (busy !== 1'b0 || div_ready !== 1'b1) begin
            errors++;
            $display("FAIL cancel_idle accept: busy=%b ready=%b want 0 1", busy, div_ready);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (res_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL cancel_idle activity: got busy/valid=1 want 0");
        end
    endtask

    task automatic test_hold();
        logic [31:0] q0, r0;
        run_op(32'd1000, 32'd33, 1'b0, 32'd30, 32'd10, 34, 1'b0, "hold_op");
        q0 = res_quot; r0 = res_rem;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (res_valid !== 1'b1 || busy !== 1'b1 || div_ready !== 1'b0 ||
                res_quot !== 32'd30 || res_rem !== 32'd10) begin
                errors++;
                $display("FAIL hold cycle %0d: valid=%b busy=%b ready=%b quot=%h rem=%h want 1 1 0 %h %h",
                         i, res_valid, busy, div_ready, res_quot, res_rem, q0, r0);
            end
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || div_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold release: busy=%b valid=%b ready=%b want 0 0 1", busy, res_valid, div_ready);
        end
    endtask

    task automatic test_back_to_back();
        run_op(32'd77, 32'd10, 1'b0, 32'd7, 32'd7, 34, 1'b0, "b2b_first");
        // New request offered in the same cycle as the result handshake.
        res_ready = 1'b1; div_valid = 1'b1; div_a = 32'd50; div_b = 32'd5; div_signed = 1'b0;
        @(posedge clk); #1;
        res_ready = 1'b0; div_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || div_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b no_accept_on_ack: busy=%b ready=%b want 0 1", busy, div_ready);
        end
        run_op(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 34, 1'b1, "b2b_second");
        // Flush beats a same-cycle result handshake and clears the result.
        run_op(32'd9, 32'd2, 1'b0, 32'd4, 32'd1, 34, 1'b0, "b2b_cancel_done");
        res_ready = 1'b1; cancel = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0; cancel = 1'b0;
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || res_quot !== 32'd0 || res_rem !== 32'd0) begin
            errors++;
            $display("FAIL cancel_done: busy=%b valid=%b quot=%h rem=%h want 0 0 0 0",
                     busy, res_valid, res_quot, res_rem);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_cancel();
        test_cancel_idle();
        test_hold();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_seq.md
# div_seq

Iterative 32-bit signed/unsigned divider controller for the EXE stage; it serves MIPS DIV/DIVU. It time-multiplexes one 33-bit subtracting adder over 32 restoring-division iterations, applies sign correction, and returns {HI, LO} through a valid/ready handshake. The EXE stage issues requests and holds the pipeline while `busy` is high. The HI/LO write-back logic consumes the result.

## Interface
- `WIDTH`, default 32: operand width. Only 32 is supported.
- `clk` input 1: clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `div_valid` input 1: request strobe.
- `div_ready` output 1: request accepted this cycle when `div_valid & div_ready`.
- `div_signed` input 1: 1 selects DIV, 0 selects DIVU. Sampled on accept.
- `div_a` input WIDTH: dividend. Sampled on accept.
- `div_b` input WIDTH: divisor. Sampled on accept.
- `cancel` input 1: pipeline flush, aborts any operation in flight.
- `busy` output 1: an operation is in flight or a result is held.
- `res_valid` output 1: the result is available.
- `res_ready` input 1: the consumer accepts the result.
- `res_quot` output WIDTH: quotient, written to LO.
- `res_rem` output WIDTH: remainder, written to HI.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- Reset and `cancel` force IDLE with these output values:
  - `div_ready` = 1, `busy` = 0, `res_valid` = 0.
  - `res_quot` = 0, `res_rem` = 0.
- `cancel` has priority over every other event, including a same-cycle accept or a same-cycle result handshake.
- IDLE, on accept:
  - Latch `sa = div_signed & div_a[31]` and `sb = div_signed & div_b[31]`.
  - Latch magnitudes `|a|` and `|b|`. The magnitude of 0x80000000 is 0x80000000 (unsigned).
  - Clear the 33-bit partial remainder R, load the quotient register Q with `|a|`, set the iteration counter to 0, and go to CALC.
- CALC, once per cycle:
  - `T = {R[31:0], Q[31]}`, 33 bits.
  - The adder computes `T - {1'b0, |b|}` as `T + ~{1'b0, |b|} + 1` (sub op, carry-in 1).
  - If carry-out = 1 (no borrow): `R <= difference`, `Q <= {Q[30:0], 1}`.
  - Otherwise: `R <= T`, `Q <= {Q[30:0], 0}`.
  - The counter increments. After the iteration with counter = 31, go to FIX.
- FIX, one cycle:
  - `quot = (sa ^ sb) ? -Q : Q`.
  - `rem = sa ? -R[31:0] : R[31:0]`.
  - Negation is two's complement modulo 2^32. Register both results, then go to DONE.
- DONE:
  - `res_valid` = 1 and the results are held stable.
  - On `res_ready`, go to IDLE.
- `div_ready` = 1 only in IDLE. A new request cannot be accepted in the same cycle that a result handshake completes.
- `busy` = 1 in CALC, FIX and DONE.
- Divide by zero: every iteration succeeds. Results are quotient 0xFFFFFFFF and remainder = dividend magnitude; FIX then applies sign correction as normal. For example, signed -5/0 gives quotient 0x00000001 and remainder 0xFFFFFFFB.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed) gives quotient 0x80000000 and remainder 0. No trap is raised.

## Timing
- An accept in cycle N gives CALC in N+1..N+32, FIX in N+33, and `res_valid` high from N+34.
- Latency from accept to `res_valid` is 34 cycles.
- The result is held for any number of `res_ready`-low cycles.
- `cancel` in any cycle gives IDLE with `busy` = 0 on the next cycle. The aborted result is never presented.
- All outputs are registered except `div_ready`, which is a decode of the state register.

## Configuration
- `DIV_ZERO_FAST_EN`:
  - Defined: a request with `div_b` = 0 goes from IDLE directly to FIX. Q is loaded with 0xFFFFFFFF and R with `|a|`, so `res_valid` is high at N+2.
  - Undefined: divide-by-zero takes the full 34-cycle path.
  - Result values are identical in both builds.

## Test plan
- DIVU 100/7 → quotient 14, remainder 2, `res_valid` first high exactly 34 cycles after accept.
- DIV 0xFFFFFFF9/2 (-7/2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIV 7/0xFFFFFFFE → quotient 0xFFFFFFFD, remainder 1.
- DIV 0x80000000/0xFFFFFFFF → quotient 0x80000000, remainder 0. DIVU 0xFFFFFFFF/1 → quotient 0xFFFFFFFF, remainder 0.
- DIVU 123/0 → quotient 0xFFFFFFFF, remainder 123. Latency is 2 with `DIV_ZERO_FAST_EN` defined and 34 without.
- `cancel` at cycle N+10, then a new DIVU 9/3 → no stale result; quotient 3, remainder 0 after 34 cycles. Also `cancel` asserted together with `div_valid` in IDLE → no accept.
- `res_ready` held low for 5 cycles in DONE → outputs stable, `div_ready` = 0. Then `res_ready` = 1 → next cycle IDLE, `busy` = 0.
